// File: rtl/sk_add_arbiter.sv
// Round-robin arbiter feeding one shared 64-bit Sklansky adder through a two-stage pipeline.
// Optional macro SKADD_SUB_EN enables per-requester subtraction (a - b) via req_sub.

module SKadder_64 (
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        cin,
  output logic [63:0] sum,
  output logic        cout
);

  logic [63:0] gl [0:6];
  logic [63:0] pl [0:6];
  logic [63:0] carry;
  int          j;

  // Sklansky prefix tree: after level l every bit holds the group (G,P) of [i : i & ~(2^(l+1)-1)]
  always_comb begin
    j = 0;
    gl[0] = a & b;
    pl[0] = a ^ b;
    for (int l = 0; l < 6; l++) begin
      gl[l+1] = gl[l];
      pl[l+1] = pl[l];
      for (int i = 0; i < 64; i++) begin
        if (i[l] == 1'b1) begin
          j = ((i >> l) << l) - 32'sd1;
          gl[l+1][i] = gl[l][i] | (pl[l][i] & gl[l][j]);
          pl[l+1][i] = pl[l][i] & pl[l][j];
        end else begin
          gl[l+1][i] = gl[l][i];
          pl[l+1][i] = pl[l][i];
        end
      end
    end
  end

  // Final groups span [i:0], so the carry into bit i+1 folds in cin directly
  always_comb begin
    carry = 64'd0;
    carry[0] = cin;
    for (int i = 0; i < 63; i++) begin
      carry[i+1] = gl[6][i] | (pl[6][i] & cin);
    end
    sum  = pl[0] ^ carry;
    cout = gl[6][63] | (pl[6][63] & cin);
  end

endmodule

module sk_add_arbiter #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [64*NREQ-1:0]   req_a,
  input  logic [64*NREQ-1:0]   req_b,
  input  logic [NREQ-1:0]      req_cin,
  input  logic [NREQ-1:0]      req_sub,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [63:0]          res_sum,
  output logic                 res_cout,
  output logic [ID_W-1:0]      res_id,
  output logic                 busy
);

  // Encoding is {s1_v, s2_v} so the stage valids fall straight out of the state
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    TAIL  = 2'b01,
    HEAD  = 2'b10,
    FULL  = 2'b11
  } occ_t;

  occ_t            state;
  occ_t            state_next;
  logic            s1_v;
  logic            s2_v;
  logic            s2_adv;
  logic            s1_acc;
  logic            hs;
  logic [ID_W:0]   pick;
  logic            grant_found;
  logic [ID_W-1:0] grant;
  logic [ID_W-1:0] ptr;
  logic [63:0]     a_sel;
  logic [63:0]     b_sel;
  logic            cin_sel;
  logic [63:0]     op_b;
  logic            op_cin;
  logic [63:0]     s1_a;
  logic [63:0]     s1_b;
  logic            s1_cin;
  logic [ID_W-1:0] s1_id;
  logic [63:0]     add_sum;
  logic            add_cout;

  // Lowest rotation offset from p wins; iterating downward lets it overwrite later
  function automatic logic [ID_W:0] rr_pick(input logic [NREQ-1:0] v, input logic [ID_W-1:0] p);
    logic [ID_W:0] r;
    int            idx;
    r = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(p) + k) % NREQ;
      if (v[idx]) begin
        r = {1'b1, idx[ID_W-1:0]};
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  assign s1_v   = state[1];
  assign s2_v   = state[0];
  assign s2_adv = s1_v & (~s2_v | res_ready);
  assign s1_acc = ~s1_v | s2_adv;

  assign pick        = rr_pick(req_valid, ptr);
  assign grant_found = pick[ID_W];
  assign grant       = pick[ID_W-1:0];
  assign hs          = s1_acc & grant_found & ~rst;

  assign res_valid = s2_v;
  assign busy      = s1_v | s2_v;

  // One-hot accept to the granted requester whenever S1 can take an op
  always_comb begin
    req_ready = '0;
    if (hs) begin
      req_ready[grant] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  assign a_sel   = req_a[{grant, 6'd0} +: 64];
  assign b_sel   = req_b[{grant, 6'd0} +: 64];
  assign cin_sel = req_cin[grant];

`ifdef SKADD_SUB_EN
  assign op_b   = req_sub[grant] ? ~b_sel : b_sel;
  assign op_cin = req_sub[grant] ? 1'b1 : cin_sel;
`else
  logic unused_sub;
  assign unused_sub = ^req_sub;
  assign op_b       = b_sel;
  assign op_cin     = cin_sel;
`endif

  // Occupancy state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Occupancy next-state: S2 drains on res_ready, S1 moves on s2_adv, S1 reloads on hs
  always_comb begin
    state_next = state;
    case (state)
      EMPTY: state_next = hs ? HEAD : EMPTY;
      HEAD:  state_next = hs ? FULL : TAIL;
      TAIL: begin
        if (hs) begin
          state_next = res_ready ? HEAD : FULL;
        end else begin
          state_next = res_ready ? EMPTY : TAIL;
        end
      end
      FULL: begin
        if (res_ready) begin
          state_next = hs ? FULL : TAIL;
        end else begin
          state_next = FULL;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  // Round-robin pointer moves past the winner only on a handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (hs) begin
      ptr <= (grant == ID_W'(NREQ - 1)) ? '0 : grant + 1'b1;
    end else begin
      ptr <= ptr;
    end
  end

  // Operand register S1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_a   <= 64'd0;
      s1_b   <= 64'd0;
      s1_cin <= 1'b0;
      s1_id  <= '0;
    end else if (hs) begin
      s1_a   <= a_sel;
      s1_b   <= op_b;
      s1_cin <= op_cin;
      s1_id  <= grant;
    end else begin
      s1_a   <= s1_a;
      s1_b   <= s1_b;
      s1_cin <= s1_cin;
      s1_id  <= s1_id;
    end
  end

  SKadder_64 u_adder (
    .a    (s1_a),
    .b    (s1_b),
    .cin  (s1_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Result register S2; holds steady while stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_sum  <= 64'd0;
      res_cout <= 1'b0;
      res_id   <= '0;
    end else if (s2_adv) begin
      res_sum  <= add_sum;
      res_cout <= add_cout;
      res_id   <= s1_id;
    end else begin
      res_sum  <= res_sum;
      res_cout <= res_cout;
      res_id   <= res_id;
    end
  end

endmodule

// File: tb/tb_sk_add_arbiter.sv
// Randomized and directed bench for sk_add_arbiter against a queue-based reference model.
module tb_sk_add_arbiter;

  localparam int NREQ = 4;
  localparam int ID_W = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [64*NREQ-1:0]  req_a;
  logic [64*NREQ-1:0]  req_b;
  logic [NREQ-1:0]     req_cin;
  logic [NREQ-1:0]     req_sub;
  logic                res_valid;
  logic                res_ready;
  logic [63:0]         res_sum;
  logic                res_cout;
  logic [ID_W-1:0]     res_id;
  logic                busy;

  int n_pass = 0;
  int n_total = 0;

  sk_add_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .req_sub   (req_sub),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sum   (res_sum),
    .res_cout  (res_cout),
    .res_id    (res_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [63:0] sum;
    logic        cout;
    int          id;
  } res_t;

  res_t in_adder[$];
  res_t at_output[$];
  int   m_ptr = 0;

  function automatic res_t model_op(int k);
    res_t        r;
    logic [64:0] tot;
    logic [63:0] a;
    logic [63:0] b;
    logic        c;
    a = req_a[64*k +: 64];
    b = req_b[64*k +: 64];
    c = req_cin[k];
`ifdef SKADD_SUB_EN
    if (req_sub[k]) begin
      b = ~b;
      c = 1'b1;
    end
`endif
    tot = {1'b0, a} + {1'b0, b} + {64'd0, c};
    r.sum  = tot[63:0];
    r.cout = tot[64];
    r.id   = k;
    return r;
  endfunction

  logic [NREQ-1:0] m_ready;
  int              m_grant;
  bit              m_move;
  bit              m_acc;

  always @(negedge clk) begin
    if (rst) begin
      in_adder.delete();
      at_output.delete();
      m_ptr = 0;
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("rst_res_valid", 64'(res_valid), 64'd0);
      chk("rst_res_sum", res_sum, 64'd0);
      chk("rst_res_cout", 64'(res_cout), 64'd0);
      chk("rst_res_id", 64'(res_id), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
    end else begin
      m_move = (in_adder.size() > 0) && (at_output.size() == 0 || res_ready);
      m_acc  = (in_adder.size() == 0) || m_move;
      m_grant = -1;
      for (int k = NREQ - 1; k >= 0; k--) begin
        if (req_valid[(m_ptr + k) % NREQ]) m_grant = (m_ptr + k) % NREQ;
      end
      m_ready = '0;
      if (m_acc && m_grant >= 0) m_ready[m_grant] = 1'b1;
      chk("req_ready", 64'(req_ready), 64'(m_ready));
      chk("res_valid", 64'(res_valid), 64'(at_output.size() > 0));
      chk("busy", 64'(busy), 64'(in_adder.size() > 0 || at_output.size() > 0));
      if (at_output.size() > 0) begin
        chk("res_sum", res_sum, at_output[0].sum);
        chk("res_cout", 64'(res_cout), 64'(at_output[0].cout));
        chk("res_id", 64'(res_id), 64'(at_output[0].id));
      end
      if (at_output.size() > 0 && res_ready) void'(at_output.pop_front());
      if (m_move) at_output.push_back(in_adder.pop_front());
      if (m_ready != '0) begin
        in_adder.push_back(model_op(m_grant));
        m_ptr = (m_grant + 1) % NREQ;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    res_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic set_op(int k, logic [63:0] a, logic [63:0] b, logic c, logic s);
    req_a[64*k +: 64] = a;
    req_b[64*k +: 64] = b;
    req_cin[k] = c;
    req_sub[k] = s;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    req_cin = '0;
    req_sub = '0;
    res_ready = 1'b1;

    // reset holds req_ready low even with requests pending
    req_valid = 4'b1111;
    step();
    @(negedge clk);
    chk("reset_ready_low", 64'(req_ready), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    do_reset();

    // single op, requester 2: all-ones + 1
    set_op(2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
    req_valid = 4'b0100;
    @(negedge clk);
    chk("t1_ready", 64'(req_ready), 64'h4);
    step();
    req_valid = '0;
    step();
    @(negedge clk);
    chk("t1_valid", 64'(res_valid), 64'd1);
    chk("t1_sum", res_sum, 64'd0);
    chk("t1_cout", 64'(res_cout), 64'd1);
    chk("t1_id", 64'(res_id), 64'd2);
    step();
    step();

    // all requesters busy: strict rotation from reset
    do_reset();
    for (int k = 0; k < NREQ; k++) set_op(k, 64'h1000 + 64'(k), 64'h20, 1'b0, 1'b0);
    req_valid = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i < 8) chk("t2_grant", 64'(req_ready), 64'(4'b0001 << (i % 4)));
      if (i >= 2) begin
        chk("t2_res_valid", 64'(res_valid), 64'd1);
        chk("t2_res_id", 64'(res_id), 64'((i - 2) % 4));
      end
      step();
      if (i == 7) req_valid = '0;
    end

    // stall with continuous requests, then resume
    do_reset();
    req_valid = 4'b1111;
    res_ready = 1'b0;
    @(negedge clk);
    chk("t3_ready0", 64'(req_ready), 64'h1);
    step();
    @(negedge clk);
    chk("t3_ready1", 64'(req_ready), 64'h2);
    step();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("t3_stall_ready", 64'(req_ready), 64'd0);
      chk("t3_stall_sum", res_sum, 64'h1020);
      chk("t3_stall_id", 64'(res_id), 64'd0);
      step();
    end
    res_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t3_resume_valid", 64'(res_valid), 64'd1);
      chk("t3_resume_id", 64'(res_id), 64'(i % 4));
      step();
    end

    // reset while FULL
    res_ready = 1'b0;
    step();
    step();
    @(negedge clk);
    chk("t4_full_busy", 64'(busy), 64'd1);
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("t4_rst_valid", 64'(res_valid), 64'd0);
    chk("t4_rst_sum", res_sum, 64'd0);
    chk("t4_rst_id", 64'(res_id), 64'd0);
    chk("t4_rst_busy", 64'(busy), 64'd0);
    step();
    rst = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    chk("t4_first_grant", 64'(req_ready), 64'h1);
    step();
    req_valid = '0;
    step();
    step();

    // subtract request on requester 1
    do_reset();
    set_op(1, 64'd5, 64'd7, 1'b0, 1'b1);
    req_valid = 4'b0010;
    step();
    req_valid = '0;
    step();
    @(negedge clk);
`ifdef SKADD_SUB_EN
    chk("t5_sum_a", res_sum, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("t5_cout_a", 64'(res_cout), 64'd0);
`else
    chk("t5_sum_a", res_sum, 64'd12);
    chk("t5_cout_a", 64'(res_cout), 64'd0);
`endif
    set_op(1, 64'd7, 64'd5, 1'b0, 1'b1);
    req_valid = 4'b0010;
    step();
    req_valid = '0;
    step();
    @(negedge clk);
`ifdef SKADD_SUB_EN
    chk("t5_sum_b", res_sum, 64'd2);
    chk("t5_cout_b", 64'(res_cout), 64'd1);
`else
    chk("t5_sum_b", res_sum, 64'd12);
    chk("t5_cout_b", 64'(res_cout), 64'd0);
`endif
    req_sub = '0;
    step();

    // requester 3 withdraws while requester 1 waits behind a stall
    do_reset();
    res_ready = 1'b0;
    req_valid = 4'b0001;
    @(negedge clk);
    chk("t6_ready0", 64'(req_ready), 64'h1);
    step();
    @(negedge clk);
    chk("t6_ready1", 64'(req_ready), 64'h1);
    step();
    req_valid = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_stall_ready", 64'(req_ready), 64'd0);
      step();
    end
    req_valid = 4'b0010;
    res_ready = 1'b1;
    @(negedge clk);
    chk("t6_serve_1", 64'(req_ready), 64'h2);
    chk("t6_no_r3", 64'(req_ready[3]), 64'd0);
    step();
    req_valid = '0;
    @(negedge clk);
    chk("t6_res0", 64'(res_id), 64'd0);
    step();
    @(negedge clk);
    chk("t6_res1_valid", 64'(res_valid), 64'd1);
    chk("t6_res1", 64'(res_id), 64'd1);
    step();

    // randomized traffic
    do_reset();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      req_valid = NREQ'($urandom);
      for (int k = 0; k < NREQ; k++) begin
        case ($urandom_range(3, 0))
          0: set_op(k, 64'hFFFF_FFFF_FFFF_FFFF, 64'($urandom_range(2, 0)), 1'($urandom), 1'($urandom));
          1: set_op(k, 64'($urandom_range(15, 0)), 64'($urandom_range(15, 0)), 1'($urandom), 1'($urandom));
          default: set_op(k, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'($urandom));
        endcase
      end
      res_ready = ($urandom_range(3, 0) != 0);
      rst = ($urandom_range(299, 0) == 0);
      step();
    end
    rst = 1'b0;
    req_valid = '0;
    res_ready = 1'b1;
    step();
    step();
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sk_add_arbiter.md
# sk_add_arbiter

Round-robin arbiter and two-stage pipeline that shares one instance of the 64-bit Sklansky prefix adder (SKadder_64) among NREQ requesters. Each requester presents operands under a valid/ready handshake. The block registers the granted operands, evaluates the shared adder for one cycle and returns the sum, carry-out and requester ID through a back-pressured result port. It sits between independent datapath clients and the single physical adder, sustaining one addition per cycle when the result port is not stalled.

## Interface
- NREQ, 4, number of requesters (2..8)
- ID_W, 2, width of requester ID; must satisfy 2**ID_W >= NREQ
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  per-requester operand valid
- req_ready  out  NREQ  per-requester accept; one-hot or zero
- req_a  in  64*NREQ  operand A, requester k at bits [64k+63:64k]
- req_b  in  64*NREQ  operand B, same packing
- req_cin  in  NREQ  carry-in per requester
- req_sub  in  NREQ  subtract request; used only with SKADD_SUB_EN
- res_valid  out  1  result valid
- res_ready  in  1  result consumer accept
- res_sum  out  64  registered sum
- res_cout  out  1  registered carry-out
- res_id  out  ID_W  index of the requester that issued the result
- busy  out  1  high while either pipeline stage holds data

## Operation
- Stage S1 holds the operand register: a, b, cin, id and s1_v. Stage S2 holds the result register: sum, cout, id and s2_v. The adder sits combinationally between S1 and S2.
- Occupancy FSM, derived from {s1_v, s2_v}:
  - EMPTY: 00.
  - HEAD: 10, op in adder.
  - TAIL: 01, result waiting.
  - FULL: 11.
- Advance rules:
  - s2_adv = s1_v & (!s2_v | res_ready).
  - s1_acc = !s1_v | s2_adv.
- Arbitration:
  - Round-robin pointer ptr: the highest-priority requester is ptr, then ptr+1, and so on, wrapping modulo NREQ.
  - grant = first k with req_valid[k], searched from ptr.
  - req_ready[k] = s1_acc & grant==k. This is combinational from req_valid, res_ready and state.
  - On handshake, ptr <= grant+1 mod NREQ. ptr does not change without a handshake.
- No grant lock. A requester may drop req_valid before its handshake; arbitration re-evaluates every cycle.
- Handshake at requester k latches req_a[k], req_b[k], req_cin[k] and id=k into S1.
- S1->S2 transfer latches the adder sum and cout with the S1 id.
- res_valid = s2_v. The result is consumed on res_valid & res_ready.
- Simultaneous events: in FULL with res_ready=1, S2 drains, S1 moves to S2, and a new grant loads S1, all in the same cycle.
- busy = s1_v | s2_v.
- Reset (any time, including mid-operation):
  - s1_v, s2_v, ptr cleared; in-flight ops discarded.
  - req_ready=0, res_valid=0, res_sum=0, res_cout=0, res_id=0, busy=0.

## Timing
- Latency from handshake at edge N to res_valid high: after edge N+1, i.e. 2 cycles.
- Throughput: 1 op/cycle with res_ready held high.
- With res_ready low, S2 holds and S1 fills. All req_ready stay 0 until res_ready rises. Stalled res_sum, res_cout and res_id stay stable.
- The adder path is a single cycle, from S1 register to S2 register.

## Configuration
- SKADD_SUB_EN defined:
  - Requester k with req_sub[k]=1 presents b inverted and cin forced to 1 to S1; req_cin[k] is ignored for that op.
  - The result is a−b mod 2^64.
  - res_cout=1 means no borrow, i.e. a>=b unsigned.
- SKADD_SUB_EN undefined:
  - req_sub is unconnected internally; every op is a+b+cin.
  - Port list is unchanged.

## Test plan
- Single op, requester 2, a=0xFFFFFFFFFFFFFFFF, b=1, cin=0, res_ready=1:
  - req_ready[2] pulses at handshake.
  - Two cycles later: res_valid=1, res_sum=0, res_cout=1, res_id=2.
- All four req_valid high for 8 cycles, res_ready=1, from reset:
  - Grants in order 0,1,2,3,0,1,2,3, one per cycle.
  - res_id follows the same sequence, starting 2 cycles after the first grant.
- res_ready=0 with continuous requests:
  - After two handshakes, req_ready=0 and res_sum holds the first result.
  - Raising res_ready resumes 1 op/cycle with no loss or duplication.
- rst asserted while FULL:
  - The same cycle shows res_valid=0, res_sum=0, res_id=0, busy=0.
  - The first grant after release goes to requester 0.
- With SKADD_SUB_EN, requester 1, a=5, b=7, req_sub=1:
  - res_sum=0xFFFFFFFFFFFFFFFE, res_cout=0.
  - a=7, b=5 gives res_sum=2, res_cout=1.
  - Without the macro, the same op gives res_sum=12, res_cout=0.
- Requester 3 drops req_valid while requester 1 holds the grant under stall:
  - When res_ready rises, requester 1 is served.
  - Requester 3 receives no req_ready pulse.
